// File: rtl/lfsr_checker.sv
// lfsr_checker: checks a received 10-bit PRBS stream, acquiring lock from a
// seed word and counting mismatches once locked.
module lfsr_checker #(
    parameter int LOCK_MATCHES = 4,
    parameter int UNLOCK_ERRS  = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [10:1]      in_data,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
);
    localparam int MW = $clog2(LOCK_MATCHES + 1);
    localparam int BW = $clog2(UNLOCK_ERRS + 1);
    localparam logic [MW-1:0] M_ONE = 1;
    localparam logic [BW-1:0] B_ONE = 1;
    localparam logic [MW-1:0] M_LIM = MW'(LOCK_MATCHES);
    localparam logic [BW-1:0] B_LIM = BW'(UNLOCK_ERRS);
    localparam logic [CNT_W-1:0] C_ONE = 1;
    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;
    state_t state;
    logic [10:1] exp, nxt_in, nxt_exp;
    logic [MW-1:0] match_cnt, mc_inc;
    logic [BW-1:0] bad_cnt, bc_inc;
    logic hit;
    // All-zero is not on the sequence; it maps to the word after 0x001.
    function automatic logic [10:1] next_word(input logic [10:1] x);
        return (x == '0) ? 10'h002
                         : {x[9:6], x[10] ^ x[5], x[10] ^ x[4], x[10] ^ x[3], x[2], x[1], x[10]};
    endfunction
    always_comb begin
        hit     = in_data == exp;
        nxt_in  = next_word(in_data);
        nxt_exp = next_word(exp);
        mc_inc  = match_cnt + M_ONE;
        bc_inc  = bad_cnt + B_ONE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            exp       <= 10'h001;
            match_cnt <= '0;
            bad_cnt   <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (clr_cnt) err_count <= '0;
            if (in_valid) begin
                case (state)
                    HUNT: begin
                        exp       <= nxt_in;
                        match_cnt <= '0;
                        state     <= VERIFY;
                    end
                    VERIFY: begin
                        if (hit) begin
                            exp <= nxt_exp;
                            if (mc_inc == M_LIM) begin
                                state     <= LOCKED;
                                locked    <= 1'b1;
                                match_cnt <= '0;
                                bad_cnt   <= '0;
                            end else begin
                                match_cnt <= mc_inc;
                            end
                        end else begin
                            exp       <= nxt_in;
                            match_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Once locked the local generator free-runs; errors never reseed it.
                        exp <= nxt_exp;
                        if (hit) begin
                            bad_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                            if (!clr_cnt && err_count != '1) err_count <= err_count + C_ONE;
                            if (bc_inc == B_LIM) begin
                                state   <= HUNT;
                                locked  <= 1'b0;
                                bad_cnt <= '0;
                            end else begin
                                bad_cnt <= bc_inc;
                            end
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 SHALL have parameter LOCK_MATCHES, default 4, meaning the number of consecutive correct samples after the seed that are required to declare lock.
REQ-002 SHALL have parameter UNLOCK_ERRS, default 3, meaning the number of consecutive mismatches in LOCKED that force a return to HUNT.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the width of err_count.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit; in_data is sampled only when in_valid is high.
REQ-007 SHALL have port in_data, input, 10 bits [10:1]; this is the received pseudo-random word.
REQ-008 SHALL have port clr_cnt, input, 1 bit; it synchronously clears err_count.
REQ-009 SHALL have port locked, output, 1 bit; it is high while the FSM is in LOCKED.
REQ-010 SHALL have port err_pulse, output, 1 bit; it is a one-cycle flag for each mismatch detected in LOCKED.
REQ-011 SHALL have port err_count, output, CNT_W bits; it is a saturating count of mismatches detected in LOCKED.

Function
REQ-012 SHALL define next(x) for 10-bit x[10:1] as follows: n[10:7]=x[9:6], n[6]=x[10]^x[5], n[5]=x[10]^x[4], n[4]=x[10]^x[3], n[3]=x[2], n[2]=x[1], n[1]=x[10]; the exception is next(0x000)=0x002.
REQ-013 SHALL hold an internal 10-bit register exp, the expected next word.
REQ-014 SHALL implement three FSM states: HUNT, VERIFY and LOCKED; no state changes when in_valid is low.
REQ-015 SHALL, in HUNT on a valid sample: exp<=next(in_data), match_cnt<=0, go to VERIFY.
REQ-016 SHALL, in VERIFY on a valid sample that matches (in_data==exp): exp<=next(exp), match_cnt+1; go to LOCKED when match_cnt+1 == LOCK_MATCHES.
REQ-017 SHALL, in VERIFY on a valid sample that mismatches: reseed with exp<=next(in_data), match_cnt<=0, stay in VERIFY; no error is counted.
REQ-018 SHALL, in LOCKED on every valid sample, set exp<=next(exp) whether or not the sample matches; a mismatch never causes a reseed.
REQ-019 SHALL, in LOCKED on a mismatch: err_pulse=1 in the next cycle, err_count+1 saturating at all-ones, bad_cnt+1; when bad_cnt+1 == UNLOCK_ERRS, go to HUNT.
REQ-020 SHALL, in LOCKED on a match, clear bad_cnt to 0.
REQ-021 SHALL register all outputs; locked and err_pulse reflect the sample accepted in the previous cycle, giving a latency of 1 cycle.
REQ-022 SHALL give clr_cnt priority over an increment: if clr_cnt and a counted mismatch occur in the same cycle, err_count=0 while err_pulse is still asserted.
REQ-023 SHALL leave err_count unchanged on return to HUNT; it changes only by increment or clr_cnt.
REQ-024 SHALL treat a zero word as ordinary data: in HUNT it seeds exp=0x002, and in LOCKED it is a mismatch unless exp==0x000 (unreachable).

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force: state=HUNT, exp=0x001, match_cnt=0, bad_cnt=0, locked=0, err_pulse=0, err_count=0.
REQ-026 SHALL, when rst_n is asserted mid-operation, discard any lock and partial match count; after release the block restarts in HUNT.

Verification
REQ-027 SHALL cover lock-up: valid samples 0x001,0x002,0x004,0x008,0x010 on consecutive cycles -> locked=1 on the cycle after 0x010 is accepted; err_count=0.
REQ-028 SHALL cover a single error: after lock, send 0x3FF in place of 0x020, then 0x040,0x080,0x100,0x200,0x039 -> one err_pulse, err_count=1, locked stays 1.
REQ-029 SHALL cover unlock: after lock, send three consecutive mismatching words -> err_count=3, locked=0 on the cycle after the third; the next valid sample is taken as the seed.
REQ-030 SHALL cover a reseed in VERIFY: send 0x001,0x002,0x155,0x2AA,... followed by the correct successors of 0x155 -> no err_pulse; locked after 4 matches following 0x155.
REQ-031 SHALL cover clear with a simultaneous error: err_count=5, then clr_cnt=1 in the same cycle as a LOCKED mismatch -> err_pulse=1, err_count=0.
REQ-032 SHALL cover valid gaps and reset: in LOCKED, in_valid low for 10 cycles -> no state change; assert rst_n=0 mid-stream -> all outputs 0 immediately, state HUNT.
